// File: rtl/pwm_fade_scheduler.sv
// Per-channel duty fade scheduler: on each PWM period tick it walks every channel
// and issues one handshaked duty write per channel whose current duty is off-target.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for a period tick
// SCAN  | comparing cur/tgt of channel idx, skip or launch a write
// WRITE | duty write for channel idx held until duty_ack_i
module pwm_fade_scheduler #(
  parameter int NUM_CH = 32,
  parameter int CH_W   = 5,
  parameter int DUTY_W = 8
) (
  input  logic              CLK_IP_i,
  input  logic              RST_IP_i,
  input  logic              cfg_we_i,
  input  logic [CH_W-1:0]   cfg_ch_i,
  input  logic [DUTY_W-1:0] cfg_target_i,
  input  logic [DUTY_W-1:0] cfg_step_i,
  input  logic              tick_i,
  input  logic              ovr_clr_i,
  output logic              duty_wr_o,
  output logic [CH_W-1:0]   duty_ch_o,
  output logic [DUTY_W-1:0] duty_val_o,
  input  logic              duty_ack_i,
  output logic              busy_o,
  output logic              scan_done_o,
  output logic              overrun_o,
  output logic [NUM_CH-1:0] done_mask_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_WRITE} state_t;

  localparam logic [CH_W-1:0] LAST_IDX = CH_W'(NUM_CH - 1);

  state_t            state_q, state_d;
  logic [CH_W-1:0]   idx_q, idx_d;
  logic [DUTY_W-1:0] cur_q [NUM_CH];
  logic [DUTY_W-1:0] cur_d [NUM_CH];
  logic [DUTY_W-1:0] tgt_q [NUM_CH];
  logic [DUTY_W-1:0] tgt_d [NUM_CH];
  logic [DUTY_W-1:0] step_q [NUM_CH];
  logic [DUTY_W-1:0] step_d [NUM_CH];
  logic              duty_wr_q, duty_wr_d;
  logic [CH_W-1:0]   duty_ch_q, duty_ch_d;
  logic [DUTY_W-1:0] duty_val_q, duty_val_d;
  logic              scan_done_q, scan_done_d;
  logic              overrun_q, overrun_d;

  logic [DUTY_W:0]   cur_x, tgt_x, step_x, diff_x, nxt_x;
  logic [DUTY_W-1:0] nxt;

  // Widened arithmetic so cur +/- step never wraps; result is clamped to tgt.
  always_comb begin
    cur_x  = {1'b0, cur_q[idx_q]};
    tgt_x  = {1'b0, tgt_q[idx_q]};
    step_x = {1'b0, step_q[idx_q]};
    diff_x = '0;
    nxt_x  = tgt_x;
    if (step_x != '0) begin
      if (tgt_x > cur_x) begin
        diff_x = tgt_x - cur_x;
        nxt_x  = (diff_x <= step_x) ? tgt_x : cur_x + step_x;
      end else if (tgt_x < cur_x) begin
        diff_x = cur_x - tgt_x;
        nxt_x  = (diff_x <= step_x) ? tgt_x : cur_x - step_x;
      end
    end
    nxt = nxt_x[DUTY_W-1:0];
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_d       = cur_q;
    tgt_d       = tgt_q;
    step_d      = step_q;
    duty_wr_d   = duty_wr_q;
    duty_ch_d   = duty_ch_q;
    duty_val_d  = duty_val_q;
    scan_done_d = 1'b0;
    overrun_d   = overrun_q;

    if (cfg_we_i && (int'(cfg_ch_i) < NUM_CH)) begin
      tgt_d[cfg_ch_i]  = cfg_target_i;
      step_d[cfg_ch_i] = cfg_step_i;
    end

    // The scan_done cycle still belongs to the finishing scan, so a tick there is an overrun.
    if (ovr_clr_i) overrun_d = 1'b0;
    if (tick_i && ((state_q != ST_IDLE) || scan_done_q)) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (tick_i && !scan_done_q) begin
          state_d = ST_SCAN;
          idx_d   = '0;
        end
      end
      ST_SCAN: begin
        if (cur_q[idx_q] == tgt_q[idx_q]) begin
          if (idx_q == LAST_IDX) begin
            state_d     = ST_IDLE;
            scan_done_d = 1'b1;
          end else begin
            idx_d = idx_q + CH_W'(1);
          end
        end else begin
          duty_wr_d  = 1'b1;
          duty_ch_d  = idx_q;
          duty_val_d = nxt;
          state_d    = ST_WRITE;
        end
      end
      ST_WRITE: begin
        if (duty_ack_i) begin
          cur_d[idx_q] = duty_val_q;
          duty_wr_d    = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d     = ST_IDLE;
            scan_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + CH_W'(1);
            state_d = ST_SCAN;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK_IP_i) begin
    if (RST_IP_i) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        cur_q[i]  <= '0;
        tgt_q[i]  <= '0;
        step_q[i] <= '0;
      end
      duty_wr_q   <= 1'b0;
      duty_ch_q   <= '0;
      duty_val_q  <= '0;
      scan_done_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_q       <= cur_d;
      tgt_q       <= tgt_d;
      step_q      <= step_d;
      duty_wr_q   <= duty_wr_d;
      duty_ch_q   <= duty_ch_d;
      duty_val_q  <= duty_val_d;
      scan_done_q <= scan_done_d;
      overrun_q   <= overrun_d;
    end
  end

  always_comb begin
    done_mask_o = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      done_mask_o[i] = (cur_q[i] == tgt_q[i]);
    end
  end

  assign duty_wr_o   = duty_wr_q;
  assign duty_ch_o   = duty_ch_q;
  assign duty_val_o  = duty_val_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign scan_done_o = scan_done_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_pwm_fade_scheduler.sv
// Directed bench for pwm_fade_scheduler: fade ramps, saturation, delayed ack,
// overrun handling and reset during a pending write.
module tb_pwm_fade_scheduler;

  localparam int NUM_CH = 32;
  localparam int CH_W   = 5;
  localparam int DUTY_W = 8;

  logic              clk = 1'b0;
  logic              rst;
  logic              cfg_we;
  logic [CH_W-1:0]   cfg_ch;
  logic [DUTY_W-1:0] cfg_target;
  logic [DUTY_W-1:0] cfg_step;
  logic              tick;
  logic              ovr_clr;
  logic              duty_wr;
  logic [CH_W-1:0]   duty_ch;
  logic [DUTY_W-1:0] duty_val;
  logic              duty_ack;
  logic              busy;
  logic              scan_done;
  logic              overrun;
  logic [NUM_CH-1:0] done_mask;

  int n_chk = 0;
  int n_fail = 0;
  int cyc, wr_cnt;
  int first_ch, first_val, last_ch, last_val;

  always #5 clk = ~clk;

  pwm_fade_scheduler #(.NUM_CH(NUM_CH), .CH_W(CH_W), .DUTY_W(DUTY_W)) dut (
    .CLK_IP_i    (clk),
    .RST_IP_i    (rst),
    .cfg_we_i    (cfg_we),
    .cfg_ch_i    (cfg_ch),
    .cfg_target_i(cfg_target),
    .cfg_step_i  (cfg_step),
    .tick_i      (tick),
    .ovr_clr_i   (ovr_clr),
    .duty_wr_o   (duty_wr),
    .duty_ch_o   (duty_ch),
    .duty_val_o  (duty_val),
    .duty_ack_i  (duty_ack),
    .busy_o      (busy),
    .scan_done_o (scan_done),
    .overrun_o   (overrun),
    .done_mask_o (done_mask)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cfg(input int ch, input int tgt, input int stp);
    cfg_we     = 1'b1;
    cfg_ch     = CH_W'(ch);
    cfg_target = DUTY_W'(tgt);
    cfg_step   = DUTY_W'(stp);
    step();
    cfg_we     = 1'b0;
  endtask

  // Steps until scan_done, recording writes; cyc = -1 if the bound expires.
  task automatic wait_done();
    cyc = -1; wr_cnt = 0;
    first_ch = -1; first_val = -1; last_ch = -1; last_val = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (duty_wr) begin
        if (wr_cnt == 0) begin
          first_ch = int'(duty_ch); first_val = int'(duty_val);
        end
        last_ch = int'(duty_ch); last_val = int'(duty_val);
        wr_cnt++;
      end
      if (scan_done) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic do_scan();
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    wait_done();
  endtask

  initial begin
    rst = 1'b1; cfg_we = 1'b0; cfg_ch = '0; cfg_target = '0; cfg_step = '0;
    tick = 1'b0; ovr_clr = 1'b0; duty_ack = 1'b0;
    step(); step();
    rst = 1'b0;
    chk("rst_wr", duty_wr, 0);
    chk("rst_ch", duty_ch, 0);
    chk("rst_val", duty_val, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", scan_done, 0);
    chk("rst_ovr", overrun, 0);
    chk("rst_mask", done_mask, 32'hFFFF_FFFF);

    // Idle scan: every channel skipped
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("idle_busy", busy, 1);
    wait_done();
    chk("idle_cyc", cyc, 32);
    chk("idle_writes", wr_cnt, 0);
    chk("idle_busy_end", busy, 0);
    chk("idle_mask", done_mask, 32'hFFFF_FFFF);
    step();
    chk("idle_done_pulse", scan_done, 0);

    // ch3 ramp 0 -> 10 by 4
    duty_ack = 1'b1;
    cfg(3, 10, 4);
    chk("ramp_mask0", done_mask, 32'hFFFF_FFF7);
    do_scan();
    chk("ramp1_cyc", cyc, 33);
    chk("ramp1_n", wr_cnt, 1);
    chk("ramp1_ch", last_ch, 3);
    chk("ramp1_val", last_val, 4);
    do_scan();
    chk("ramp2_val", last_val, 8);
    chk("ramp2_mask", done_mask[3], 0);
    do_scan();
    chk("ramp3_val", last_val, 10);
    chk("ramp3_mask", done_mask, 32'hFFFF_FFFF);
    do_scan();
    chk("ramp4_n", wr_cnt, 0);
    chk("ramp4_cyc", cyc, 32);

    // ch0 jumps and saturation
    cfg(0, 200, 0);
    do_scan();
    chk("jump200_val", last_val, 200);
    chk("jump200_ch", last_ch, 0);
    cfg(0, 5, 0);
    do_scan();
    chk("jump5_n", wr_cnt, 1);
    chk("jump5_val", last_val, 5);
    cfg(0, 100, 0);
    do_scan();
    chk("jump100_val", last_val, 100);
    cfg(0, 255, 200);
    do_scan();
    chk("sat255_val", last_val, 255);
    cfg(0, 0, 100);
    do_scan();
    chk("down155_val", last_val, 155);
    cfg(0, 155, 0);
    chk("ch0_parked", done_mask, 32'hFFFF_FFFF);

    // ch7 with ack held off; retarget during the hold
    duty_ack = 1'b0;
    cfg(7, 50, 20);
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int i = 0; i < 8; i++) step();
    for (int i = 0; i < 5; i++) begin
      chk("hold_wr", duty_wr, 1);
      chk("hold_ch", duty_ch, 7);
      chk("hold_val", duty_val, 20);
      if (i == 1) begin
        cfg_we = 1'b1; cfg_ch = 5'd7; cfg_target = 8'd90; cfg_step = 8'd90;
      end
      if (i == 2) cfg_we = 1'b0;
      if (i == 4) duty_ack = 1'b1;
      step();
    end
    chk("hold_wr_drop", duty_wr, 0);
    chk("hold_busy", busy, 1);
    wait_done();
    chk("hold_rest_cyc", cyc, 24);
    chk("hold_mask7", done_mask[7], 0);
    do_scan();
    chk("retgt_val", last_val, 90);
    chk("retgt_ch", last_ch, 7);

    // Overrun: tick while busy
    chk("ovr_pre", overrun, 0);
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step(); step(); step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("ovr_set", overrun, 1);
    wait_done();
    chk("ovr_no_restart", cyc, 28);
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    step();
    tick = 1'b1; ovr_clr = 1'b1;
    step();
    tick = 1'b0; ovr_clr = 1'b0;
    chk("ovr_set_wins", overrun, 1);
    ovr_clr = 1'b1;
    step();
    ovr_clr = 1'b0;
    chk("ovr_clr", overrun, 0);
    wait_done();
    chk("ovr_scan_end", busy, 0);

    // Reset while a write is pending on ch5
    duty_ack = 1'b0;
    cfg(5, 30, 0);
    step();
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int i = 0; i < 6; i++) step();
    chk("rw_wr", duty_wr, 1);
    chk("rw_ch", duty_ch, 5);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rw_wr_drop", duty_wr, 0);
    chk("rw_busy", busy, 0);
    chk("rw_val", duty_val, 0);
    chk("rw_mask", done_mask, 32'hFFFF_FFFF);
    duty_ack = 1'b1;
    cfg(0, 1, 0);
    cfg(5, 30, 10);
    do_scan();
    chk("rw_first_ch", first_ch, 0);
    chk("rw_first_val", first_val, 1);
    chk("rw_last_ch", last_ch, 5);
    chk("rw_last_val", last_val, 10);
    chk("rw_cyc", cyc, 34);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_fade_scheduler.md
# pwm_fade_scheduler

Sequences duty-cycle updates for the multi-channel PWM output bank. Software programs a per-channel target duty and step size through the IP register block. On each PWM period-boundary tick the block scans all channels and moves each one's current duty toward its target, issuing one handshaked duty write per changed channel to the PWM datapath. It sits inside the FPGA IP between the Wishbone register decode and the PWM channel array, in the CLK_IP_i domain.

## Interface

- NUM_CH, 32, number of PWM channels (2..32)
- CH_W, 5, channel index width; must equal clog2(NUM_CH)
- DUTY_W, 8, duty/target/step width

- CLK_IP_i  in  1  IP clock; one clock, all logic on rising edge
- RST_IP_i  in  1  reset, synchronous, active-high
- cfg_we_i  in  1  config write strobe (one cycle per write)
- cfg_ch_i  in  CH_W  channel addressed by the config write
- cfg_target_i  in  DUTY_W  new target duty
- cfg_step_i  in  DUTY_W  new step per tick; 0 = jump straight to target
- tick_i  in  1  one-cycle pulse at PWM period wrap
- ovr_clr_i  in  1  clears overrun_o
- duty_wr_o  out  1  duty write request to PWM bank
- duty_ch_o  out  CH_W  channel being written
- duty_val_o  out  DUTY_W  duty value being written
- duty_ack_i  in  1  PWM bank accepted the write
- busy_o  out  1  scan in progress (state != IDLE)
- scan_done_o  out  1  one-cycle pulse when a scan finishes
- overrun_o  out  1  sticky: tick arrived while busy
- done_mask_o  out  NUM_CH  bit n = 1 when cur[n] == tgt[n]

## Operation

- Per-channel state: cur[n], tgt[n], step[n], each DUTY_W bits.
- Config write: on cfg_we_i, tgt[cfg_ch_i] <= cfg_target_i, step[cfg_ch_i] <= cfg_step_i. Accepted in any FSM state; cur is never touched by config. Out-of-range cfg_ch_i (>= NUM_CH) is ignored.
- FSM states IDLE, SCAN, WRITE.
  - IDLE: tick_i -> idx <= 0, go SCAN. Otherwise stay.
  - SCAN: if cur[idx] == tgt[idx] -> skip: if idx == NUM_CH-1 go IDLE and pulse scan_done_o, else idx++ and stay. Else latch nxt, drive duty_wr_o/duty_ch_o=idx/duty_val_o=nxt, go WRITE.
  - WRITE: hold duty_wr_o, duty_ch_o, duty_val_o stable until duty_ack_i. On ack: cur[idx] <= nxt, deassert duty_wr_o next cycle; if idx == NUM_CH-1 go IDLE with scan_done_o pulse, else idx++ and go SCAN.
- Next-value arithmetic (DUTY_W+1-bit intermediate, no wrap):
  - step == 0: nxt = tgt.
  - tgt > cur: nxt = (tgt - cur <= step) ? tgt : cur + step.
  - tgt < cur: nxt = (cur - tgt <= step) ? tgt : cur - step.
  - nxt always lies between cur and tgt inclusive; never overshoots.
- nxt is computed from tgt/step as sampled in the SCAN cycle. A config write to the channel currently in WRITE does not change duty_val_o and takes effect on the next tick.
- tick_i in any state other than IDLE is dropped and sets overrun_o. ovr_clr_i clears it; if tick_i-while-busy and ovr_clr_i coincide, set wins.
- duty_ack_i outside WRITE is ignored.
- done_mask_o is combinational from the cur/tgt registers.

## Timing

- Reset values: state IDLE, idx 0, all cur/tgt/step 0, duty_wr_o 0, duty_ch_o 0, duty_val_o 0, busy_o 0, scan_done_o 0, overrun_o 0, done_mask_o all ones.
- Reset asserted mid-scan: duty_wr_o drops on the next edge and all state returns to reset values. The pending write is abandoned and no cur update occurs.
- tick_i in IDLE at cycle t: busy_o = 1 and SCAN begins at t+1.
- Skipped channel: 1 cycle. Written channel with same-cycle ack: SCAN 1 + WRITE 1 = 2 cycles.
- Minimum scan: NUM_CH cycles. Maximum with immediate ack: 2*NUM_CH cycles.
- scan_done_o pulses in the cycle the FSM enters IDLE, and busy_o falls in the same cycle.
- A tick in the same cycle as scan_done_o counts as overrun.

## Test plan

- Reset, then tick with all channels idle -> no duty_wr_o; scan_done_o exactly 32 cycles after tick; done_mask_o = 0xFFFFFFFF.
- ch3 tgt=10 step=4, ack tied high, 3 ticks -> writes ch3 values 4, 8, 10; 4th tick produces no write; done_mask_o[3] returns to 1 after the 3rd write.
- ch0 cur=200 (ramped), reprogrammed to tgt=5 step=0 -> single write of 5 on next tick; saturation case tgt=255 step=200 from cur=100 -> write 255 (no wrap).
- ack delayed 5 cycles on ch7 -> duty_wr_o/ch/val held stable 5 cycles. A config write to ch7 during the hold leaves duty_val_o unchanged; the new target applies on the next tick.
- tick_i during scan -> overrun_o = 1, scan not restarted. ovr_clr_i simultaneous with another busy tick -> overrun_o stays 1; ovr_clr_i alone -> 0.
- RST_IP_i asserted while in WRITE -> next cycle duty_wr_o = 0, busy_o = 0, cur of that channel = 0, subsequent tick rescans from ch0.
